// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Width of the nibble index register; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nnib);
        return (nnib <= 1) ? 1 : $clog2(nnib);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/response channel bundle between a requester and the sequencer.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             c_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             busy;

    modport master (
        output req_valid, op_a, op_b, sub, c_in, rsp_ready,
        input  req_ready, rsp_valid, result, c_out, overflow, busy
    );

    modport slave (
        input  req_valid, op_a, op_b, sub, c_in, rsp_ready,
        output req_ready, rsp_valid, result, c_out, overflow, busy
    );
endinterface

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder built from full-adder slices.
module nibble_add4
    import nibble_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co,
    output logic             c3
);

    // Ripple the carry through one full-adder slice per bit; c3 is the carry into the top bit.
    always_comb begin
        logic carry;
        carry = ci;
        s     = '0;
        c3    = 1'b0;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            if (i == NIB_W - 1) begin
                c3 = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequencer reusing one 4-bit adder, one nibble per clock, LSB first.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_add_ctrl_if.slave bus
);

    localparam int NNIB = WIDTH / NIB_W;
    localparam int KW   = idx_width(NNIB);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             busy_q;
    logic             c_out_q;
    logic             ovf_q;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] s_nib;
    logic             nib_co;
    logic             nib_c3;

    assign a_nib = a_q[k_q*NIB_W +: NIB_W];
    assign b_nib = b_q[k_q*NIB_W +: NIB_W];

    nibble_add4 u_add4 (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (nib_co),
        .c3 (nib_c3)
    );

    // Sequencer: accept, walk the nibbles through the shared adder, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        // Subtract is A + ~B + 1, so B is stored inverted and the carry forced high.
                        a_q         <= bus.op_a;
                        b_q         <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry_q     <= bus.sub ? 1'b1 : bus.c_in;
                        k_q         <= '0;
                        result_q    <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    result_q[k_q*NIB_W +: NIB_W] <= s_nib;
                    carry_q <= nib_co;
                    k_q     <= k_q + KW'(1);
                    if (k_q == KW'(NNIB - 1)) begin
                        c_out_q     <= nib_co;
                        ovf_q       <= nib_c3 ^ nib_co;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.result    = result_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = busy_q;

endmodule
